// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory request in flight,
// and hands each word with its PC to decode. Optional counters under FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCsrc,
  input  logic [31:0] ImmOp
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        accept;

  assign accept = (state_q == S_HOLD) && instr_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        // Responses are only honoured here, so strobes left over from an abandoned request are dropped.
        if (imem_valid) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          fetch_pc_d = PCsrc ? (pc_q + ImmOp) : (pc_q + 32'd4);
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_VECTOR;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = fetch_pc_q;
  assign instruction = instr_q;
  assign PC          = pc_q;
  assign instr_valid = (state_q == S_HOLD);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, stall_count_q;
  logic        stall;

  // A stall is any cycle spent waiting on memory or on decode.
  assign stall = (state_q == S_WAIT) || ((state_q == S_HOLD) && !instr_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (accept) fetch_count_q <= fetch_count_q + 32'd1;
      if (stall)  stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-configurable instruction-memory model.
module tb_fetch_stage;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        PCsrc = 1'b0;
  logic [31:0] ImmOp = 32'd0;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_req = 0;

  // Memory model: auto mode answers each request after lat cycles; manual mode is driven by the bench.
  logic        mem_auto = 1'b1;
  int          lat = 1;
  int          pend = 0;
  logic [31:0] pend_addr = 32'd0;
  logic        auto_valid = 1'b0;
  logic [31:0] auto_rdata = 32'd0;
  logic        man_valid = 1'b0;
  logic [31:0] man_rdata = 32'd0;

  assign imem_valid = mem_auto ? auto_valid : man_valid;
  assign imem_rdata = mem_auto ? auto_rdata : man_rdata;

  fetch_stage #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instruction(instruction), .PC(PC), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .PCsrc(PCsrc), .ImmOp(ImmOp)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + {a[29:0], 2'b00};
  endfunction

  always @(negedge clk) begin
    if (!mem_auto) begin
      pend       <= 0;
      auto_valid <= 1'b0;
    end else if (pend == 1) begin
      pend       <= 0;
      auto_valid <= 1'b1;
      auto_rdata <= mem_word(pend_addr);
    end else if (pend > 1) begin
      pend       <= pend - 1;
      auto_valid <= 1'b0;
    end else begin
      auto_valid <= 1'b0;
      if (imem_req) begin
        pend      <= lat;
        pend_addr <= imem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic br, input logic [31:0] imm,
                          input int hold, input logic gap_chk);
    int n;
    logic [31:0] nxt;
    n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, pc);
    if (gap_chk) chk("req_gap", cyc - last_req, 32'd3);
    last_req = cyc;
    n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    chk("valid_seen", {31'd0, instr_valid}, 32'd1);
    chk("pc", PC, pc);
    chk("instr", instruction, mem_word(pc));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_noreq", {31'd0, imem_req}, 32'd0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_pc", PC, pc);
      chk("bp_instr", instruction, mem_word(pc));
    end
    instr_ready = 1'b1;
    PCsrc = br;
    ImmOp = imm;
    tick();
    instr_ready = 1'b0;
    PCsrc = 1'($urandom_range(0, 1));
    ImmOp = $urandom;
    nxt = br ? pc + imm : pc + 32'd4;
    chk("acc_req", {31'd0, imem_req}, 32'd1);
    chk("acc_valid", {31'd0, instr_valid}, 32'd0);
    chk("next_addr", imem_addr, nxt);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RV);
    chk("rst_instr", instruction, NOP);
    chk("rst_pc", PC, RV);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    rst = 1'b0;

    // T1 boot
    chk("boot_idle", {31'd0, imem_req}, 32'd0);
    tick();
    chk("boot_req", {31'd0, imem_req}, 32'd1);
    do_fetch(32'h0, 1'b0, 32'h0, 0, 1'b0);

    // T2 sequential, one request every 3 cycles
    do_fetch(32'h4, 1'b0, 32'h0, 0, 1'b1);
    do_fetch(32'h8, 1'b0, 32'h0, 0, 1'b1);
    do_fetch(32'hC, 1'b0, 32'h0, 0, 1'b1);

    // T3 branches and wrap
    do_fetch(32'h10, 1'b1, 32'hFFFF_FFF8, 0, 1'b0);
    do_fetch(32'h8, 1'b1, 32'hFFFF_FFF8, 0, 1'b0);
    do_fetch(32'h0, 1'b1, 32'hFFFF_FFFC, 0, 1'b0);
    do_fetch(32'hFFFF_FFFC, 1'b0, 32'h0, 0, 1'b0);

    // T4 backpressure
    do_fetch(32'h0, 1'b0, 32'h0, 5, 1'b0);

    // T5 reset while waiting for memory
    mem_auto = 1'b0;
    chk("t5_req_addr", imem_addr, 32'h4);
    tick();
    chk("t5_wait_noreq", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_rst_instr", instruction, NOP);
    chk("t5_rst_pc", PC, RV);
    chk("t5_rst_addr", imem_addr, RV);
    tick();
    rst = 1'b0;
    man_valid = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    chk("t5_idle_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("t5_req", {31'd0, imem_req}, 32'd1);
    chk("t5_req_rv", imem_addr, RV);
    chk("t5_req_novalid", {31'd0, instr_valid}, 32'd0);
    tick();
    man_valid = 1'b0;
    chk("t5_stale_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_stale_instr", instruction, NOP);
    man_valid = 1'b1;
    man_rdata = mem_word(32'h0);
    tick();
    man_valid = 1'b0;
    chk("t5_hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("t5_hold_instr", instruction, mem_word(32'h0));
    chk("t5_hold_pc", PC, RV);
    instr_ready = 1'b1;
    PCsrc = 1'b0;
    tick();
    instr_ready = 1'b0;
    mem_auto = 1'b1;
    chk("t5_next_addr", imem_addr, 32'h4);
    do_fetch(32'h4, 1'b0, 32'h0, 0, 1'b0);

`ifdef FETCH_PERF_EN
    // T6 performance counters, latency 3
    lat = 3;
    mem_auto = 1'b0;
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    mem_auto = 1'b1;
    chk("t6_fc0", fetch_count, 32'd0);
    chk("t6_sc0", stall_count, 32'd0);
    do_fetch(32'h0, 1'b0, 32'h0, 0, 1'b0);
    do_fetch(32'h4, 1'b0, 32'h0, 2, 1'b0);
    do_fetch(32'h8, 1'b0, 32'h0, 0, 1'b0);
    do_fetch(32'hC, 1'b0, 32'h0, 0, 1'b0);
    chk("t6_fetch_count", fetch_count, 32'd4);
    chk("t6_stall_count", stall_count, 32'd14);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
